// File: rtl/apb_uart_fifo.sv
// APB UART slave with TX/RX FIFOs, programmable baud divisor (16x oversampling),
// 5-8 data bits, optional odd/even parity, 1/2 stop bits, sticky errors and a level irq.
module apb_uart_fifo #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd26,
  parameter int          CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] padd,
  input  logic [31:0] pdata,
  input  logic        psel,
  input  logic        pen,
  input  logic        pwr,
  input  logic [3:0]  PSTRB,
  output logic [31:0] prdata,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // APB: psel&pen is the access phase; PREADY is always 1 so every register
  // side effect (push, pop, W1C, CTRL/BAUD update) fires exactly on that cycle.
  logic       w_acc, w_wr, w_rd;
  logic [1:0] w_addr;
  logic       w_data_wr, w_stat_wr, w_ctrl_wr, w_baud_wr, w_data_rd;

  assign w_acc     = psel & pen;
  assign w_wr      = w_acc & pwr;
  assign w_rd      = w_acc & ~pwr;
  assign w_addr    = padd[3:2];
  assign w_data_wr = w_wr & (w_addr == 2'd0);
  assign w_stat_wr = w_wr & (w_addr == 2'd1);
  assign w_ctrl_wr = w_wr & (w_addr == 2'd2);
  assign w_baud_wr = w_wr & (w_addr == 2'd3);
  assign w_data_rd = w_rd & (w_addr == 2'd0);

  logic w_unused_bits;
  assign w_unused_bits = ^{padd[31:4], padd[1:0], pdata[31:16], PSTRB[3:2]};

  // Control and baud registers
  logic [9:0]  r_ctrl;
  logic [15:0] r_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= 10'h00F;
      r_div  <= DEFAULT_DIV;
    end else begin
      if (w_ctrl_wr) begin
        if (PSTRB[0]) r_ctrl[7:0] <= pdata[7:0];
        if (PSTRB[1]) r_ctrl[9:8] <= pdata[9:8];
      end
      if (w_baud_wr) begin
        if (PSTRB[0]) r_div[7:0]  <= pdata[7:0];
        if (PSTRB[1]) r_div[15:8] <= pdata[15:8];
      end
    end
  end

  logic w_tx_en, w_rx_en, w_par_en, w_par_odd, w_two_stop;
  logic w_rx_irq_en, w_tx_irq_en, w_err_irq_en;
  assign w_tx_en      = r_ctrl[0];
  assign w_rx_en      = r_ctrl[1];
  assign w_par_en     = r_ctrl[4];
  assign w_par_odd    = r_ctrl[5];
  assign w_two_stop   = r_ctrl[6];
  assign w_rx_irq_en  = r_ctrl[7];
  assign w_tx_irq_en  = r_ctrl[8];
  assign w_err_irq_en = r_ctrl[9];

  // Tick generator: one tick every DIV+1 clocks
  logic [15:0] r_tick_cnt;
  logic        w_tick;
  assign w_tick = (r_tick_cnt == r_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_tick_cnt <= '0;
    else if (w_baud_wr || w_tick)  r_tick_cnt <= '0;
    else                           r_tick_cnt <= r_tick_cnt + 16'd1;
  end

  // TX FIFO
  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_tx_wptr, r_tx_rptr, r_tx_cnt;
  logic             w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0]       w_tx_head;

  assign w_tx_full  = (r_tx_cnt == CNT_W'(FIFO_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign w_tx_push  = w_data_wr & PSTRB[0] & (~w_tx_full | w_tx_pop);
  assign PSLVERR    = w_data_wr & w_tx_full & ~w_tx_pop;
  assign PREADY     = 1'b1;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= pdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // TX FSM
  state_t     r_tx_state;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_last, r_tx_bit;
  logic [4:0] r_tx_ticks;
  logic       r_tx_par_en, r_tx_par_bit, r_tx_two_stop, r_txd;
  logic       w_tx_bit_end, w_tx_stop_end, w_tx_load, w_tx_busy;
  logic [7:0] w_tx_mask, w_tx_data;

  assign w_tx_mask     = 8'hFF >> (2'd3 - r_ctrl[3:2]);
  assign w_tx_data     = w_tx_head & w_tx_mask;
  assign w_tx_bit_end  = w_tick & (r_tx_ticks == 5'd15);
  assign w_tx_stop_end = w_tick & (r_tx_ticks == (r_tx_two_stop ? 5'd31 : 5'd15));
  // Loading straight out of the last stop tick keeps frames back-to-back.
  assign w_tx_load     = w_tx_en & ~w_tx_empty &
                         ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_stop_end));
  assign w_tx_pop      = w_tx_load;
  assign w_tx_busy     = (r_tx_state != S_IDLE);
  assign txd           = r_txd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state    <= S_IDLE;
      r_tx_shift    <= '0;
      r_tx_last     <= '0;
      r_tx_bit      <= '0;
      r_tx_ticks    <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_two_stop <= 1'b0;
      r_txd         <= 1'b1;
    end else if (w_tx_load) begin
      r_tx_state    <= S_START;
      r_tx_shift    <= w_tx_data;
      r_tx_last     <= {1'b1, r_ctrl[3:2]};
      r_tx_par_en   <= w_par_en;
      r_tx_par_bit  <= (^w_tx_data) ^ w_par_odd;
      r_tx_two_stop <= w_two_stop;
      r_tx_ticks    <= '0;
      r_txd         <= 1'b0;
    end else begin
      case (r_tx_state)
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_state <= S_DATA;
            r_tx_ticks <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
          end else if (w_tick) r_tx_ticks <= r_tx_ticks + 5'd1;
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_ticks <= '0;
            if (r_tx_bit == r_tx_last) begin
              r_tx_state <= r_tx_par_en ? S_PARITY : S_STOP;
              r_txd      <= r_tx_par_en ? r_tx_par_bit : 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end else if (w_tick) r_tx_ticks <= r_tx_ticks + 5'd1;
        end
        S_PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_state <= S_STOP;
            r_tx_ticks <= '0;
            r_txd      <= 1'b1;
          end else if (w_tick) r_tx_ticks <= r_tx_ticks + 5'd1;
        end
        S_STOP: begin
          if (w_tx_stop_end) r_tx_state <= S_IDLE;
          else if (w_tick)   r_tx_ticks <= r_tx_ticks + 5'd1;
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // RX synchroniser and FSM
  logic       r_rx_s1, r_rx_s2, r_rx_prev;
  state_t     r_rx_state;
  logic [3:0] r_rx_ticks;
  logic [2:0] r_rx_bit, r_rx_last;
  logic       r_rx_par_en, r_rx_par_odd;
  logic [7:0] r_rx_data;
  logic       w_rx_smp, w_rx_done, w_rx_frm_err, w_rx_par_err;

  assign w_rx_smp     = w_tick & (r_rx_ticks == 4'd15);
  assign w_rx_done    = (r_rx_state == S_STOP) & w_rx_smp & r_rx_s2;
  assign w_rx_frm_err = (r_rx_state == S_STOP) & w_rx_smp & ~r_rx_s2;
  assign w_rx_par_err = (r_rx_state == S_PARITY) & w_rx_smp &
                        (r_rx_s2 != ((^r_rx_data) ^ r_rx_par_odd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_ticks   <= '0;
      r_rx_bit     <= '0;
      r_rx_last    <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_data    <= '0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_en && r_rx_prev && !r_rx_s2) begin
            r_rx_state   <= S_START;
            r_rx_ticks   <= '0;
            r_rx_last    <= {1'b1, r_ctrl[3:2]};
            r_rx_par_en  <= w_par_en;
            r_rx_par_odd <= w_par_odd;
            r_rx_data    <= '0;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects glitches as false starts.
          if (w_tick && r_rx_ticks == 4'd7) begin
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
            r_rx_ticks <= '0;
            r_rx_bit   <= '0;
          end else if (w_tick) r_rx_ticks <= r_rx_ticks + 4'd1;
        end
        S_DATA: begin
          if (w_rx_smp) begin
            r_rx_data[r_rx_bit] <= r_rx_s2;
            r_rx_ticks          <= '0;
            if (r_rx_bit == r_rx_last) r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
            else                       r_rx_bit   <= r_rx_bit + 3'd1;
          end else if (w_tick) r_rx_ticks <= r_rx_ticks + 4'd1;
        end
        S_PARITY: begin
          if (w_rx_smp) begin
            r_rx_state <= S_STOP;
            r_rx_ticks <= '0;
          end else if (w_tick) r_rx_ticks <= r_rx_ticks + 4'd1;
        end
        S_STOP: begin
          if (w_rx_smp)    r_rx_state <= S_IDLE;
          else if (w_tick) r_rx_ticks <= r_rx_ticks + 4'd1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // RX FIFO
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_rx_wptr, r_rx_rptr, r_rx_cnt;
  logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_ovr;
  logic [7:0]       w_rx_head;

  assign w_rx_full  = (r_rx_cnt == CNT_W'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_head  = r_rx_mem[r_rx_rptr[AW-1:0]];
  assign w_rx_pop   = w_data_rd & ~w_rx_empty;
  assign w_rx_push  = w_rx_done & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr   = w_rx_done & w_rx_full & ~w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Sticky error flags (a new event wins over a same-cycle W1C) and irq
  logic r_ovr, r_par_err, r_frm_err, r_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr     <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ovr     <= (r_ovr     & ~(w_stat_wr & pdata[5])) | w_rx_ovr;
      r_par_err <= (r_par_err & ~(w_stat_wr & pdata[6])) | w_rx_par_err;
      r_frm_err <= (r_frm_err & ~(w_stat_wr & pdata[7])) | w_rx_frm_err;
      r_irq     <= (w_rx_irq_en & ~w_rx_empty) | (w_tx_irq_en & w_tx_empty) |
                   (w_err_irq_en & (r_ovr | r_par_err | r_frm_err));
    end
  end

  assign irq = r_irq;

  // Read mux
  logic [31:0] w_status;
  assign w_status = {8'd0, 8'(r_tx_cnt), 8'(r_rx_cnt), r_frm_err, r_par_err, r_ovr,
                     w_tx_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (w_addr)
        2'd0:    prdata = {24'd0, w_rx_empty ? 8'd0 : w_rx_head};
        2'd1:    prdata = w_status;
        2'd2:    prdata = {22'd0, r_ctrl};
        default: prdata = {16'd0, r_div};
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Scoreboard bench for apb_uart_fifo: APB and serial expectations are queued by
// the stimulus and checked by independent monitors on the falling clock edge.
module tb_apb_uart_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] padd, pdata, prdata;
  logic        psel, pen, pwr, PREADY, PSLVERR;
  logic [3:0]  PSTRB;
  logic        rxd_w, txd, irq;
  logic        rxd_drv, loop, tx_mon_en;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        exp_rd_q[$];
  string       exp_name_q[$];
  logic [15:0] tx_exp_q[$];

  always #5 clk = ~clk;

  assign rxd_w = loop ? txd : rxd_drv;

  apb_uart_fifo dut (
    .clk(clk), .rst(rst), .padd(padd), .pdata(pdata), .psel(psel), .pen(pen),
    .pwr(pwr), .PSTRB(PSTRB), .prdata(prdata), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rxd(rxd_w), .txd(txd), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic exp_err, input string name);
    @(posedge clk); #1;
    exp_q.push_back({31'd0, exp_err});
    exp_rd_q.push_back(1'b0);
    exp_name_q.push_back({name, "_pslverr"});
    padd = {28'd0, a, 2'b00}; pdata = d; PSTRB = s; pwr = 1'b1; psel = 1'b1; pen = 1'b0;
    @(posedge clk); #1;
    pen = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0; pwr = 1'b0; PSTRB = 4'd0;
  endtask

  task automatic apb_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    exp_q.push_back(exp);
    exp_rd_q.push_back(1'b1);
    exp_name_q.push_back(name);
    padd = {28'd0, a, 2'b00}; pwr = 1'b0; psel = 1'b1; pen = 1'b0;
    @(posedge clk); #1;
    pen = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0;
  endtask

  task automatic tx_expect(input logic [7:0] d, input int nb, input logic pe,
                           input logic odd, input logic two);
    tx_exp_q.push_back({two, odd, pe, 1'b0, 4'(nb), d});
  endtask

  // Drives one serial frame on rxd at 16 clocks per bit (BAUD = 0).
  task automatic rx_frame(input logic [7:0] d, input int nb, input logic pe, input logic odd,
                          input logic bad_par, input logic stop_v);
    logic p;
    p = odd;
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (16) @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      rxd_drv = d[i];
      p = p ^ d[i];
      repeat (16) @(posedge clk); #1;
    end
    if (pe) begin
      rxd_drv = p ^ bad_par;
      repeat (16) @(posedge clk); #1;
    end
    rxd_drv = stop_v;
    repeat (16) @(posedge clk); #1;
    rxd_drv = 1'b1;
    repeat (8) @(posedge clk); #1;
  endtask

  // ---------------- APB monitor ----------------
  initial begin : apb_mon
    logic [31:0] e;
    logic        is_rd;
    string       nm;
    forever begin
      @(negedge clk);
      if (psel && pen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apb_unexpected: got access to %08h expected none", padd);
        end else begin
          e     = exp_q.pop_front();
          is_rd = exp_rd_q.pop_front();
          nm    = exp_name_q.pop_front();
          if (is_rd) check(nm, prdata, e);
          else       check(nm, {31'd0, PSLVERR}, e);
        end
      end
    end
  end

  // ---------------- TX line monitor ----------------
  initial begin : tx_mon
    logic        prev;
    logic [15:0] ent;
    logic [11:0] fb;
    logic [7:0]  d, m;
    logic        ok, bad_val;
    int          nb, n;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && tx_mon_en && prev && !txd) begin
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: got start bit expected idle line");
        end else begin
          ent = tx_exp_q.pop_front();
          d   = ent[7:0];
          nb  = int'(ent[11:8]);
          m   = 8'hFF >> (8 - nb);
          fb  = '0;
          n   = 1;
          for (int i = 0; i < nb; i++) begin
            fb[n] = d[i];
            n++;
          end
          if (ent[13]) begin
            fb[n] = (^(d & m)) ^ ent[14];
            n++;
          end
          fb[n] = 1'b1;
          n++;
          if (ent[15]) begin
            fb[n] = 1'b1;
            n++;
          end
          for (int b = 0; b < n; b++) begin
            ok = 1'b1;
            bad_val = fb[b];
            for (int s = 0; s < 16; s++) begin
              if (b != 0 || s != 0) @(negedge clk);
              if (txd !== fb[b]) begin
                ok = 1'b0;
                bad_val = txd;
              end
            end
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL tx_bit%0d of byte %02h: got %0b expected %0b", b, d, bad_val, fb[b]);
            end
          end
        end
      end
      prev = txd;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic seen;
    rst = 1'b0; psel = 1'b0; pen = 1'b0; pwr = 1'b0; padd = '0; pdata = '0; PSTRB = '0;
    rxd_drv = 1'b1; loop = 1'b0; tx_mon_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("pready", {31'd0, PREADY}, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    apb_read(2'd1, 32'h0000_000A, "reset_status");
    apb_read(2'd2, 32'h0000_000F, "reset_ctrl");
    apb_read(2'd3, 32'h0000_001A, "reset_baud");

    // Baud divisor with byte-lane gating
    apb_write(2'd3, 32'h0000_0000, 4'b0011, 1'b0, "baud0");
    apb_write(2'd3, 32'h0000_1234, 4'b0010, 1'b0, "baud_lane1");
    apb_read(2'd3, 32'h0000_1200, "baud_lane1_rd");
    apb_write(2'd3, 32'h0000_0000, 4'b0011, 1'b0, "baud0_again");
    apb_read(2'd3, 32'h0000_0000, "baud0_rd");

    // Single 8N1 frame 0xA5
    tx_expect(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    apb_write(2'd0, 32'h0000_00A5, 4'b0001, 1'b0, "tx_a5");
    apb_read(2'd1, 32'h0000_001A, "status_tx_busy");
    check("irq_tx_disabled", {31'd0, irq}, 32'd0);
    repeat (200) @(posedge clk);
    apb_read(2'd1, 32'h0000_000A, "status_tx_done");
    apb_write(2'd2, 32'h0000_010F, 4'b0011, 1'b0, "ctrl_tx_irq");
    repeat (3) @(posedge clk); #1;
    check("irq_tx_empty", {31'd0, irq}, 32'd1);
    apb_write(2'd2, 32'h0000_000F, 4'b0011, 1'b0, "ctrl_default");
    repeat (3) @(posedge clk); #1;
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Loopback 7 data bits, odd parity, two stop bits
    loop = 1'b1;
    apb_write(2'd2, 32'h0000_007B, 4'b0001, 1'b0, "ctrl_7o2");
    tx_expect(8'h3C, 7, 1'b1, 1'b1, 1'b1);
    tx_expect(8'h7F, 7, 1'b1, 1'b1, 1'b1);
    tx_expect(8'h00, 7, 1'b1, 1'b1, 1'b1);
    apb_write(2'd0, 32'h0000_003C, 4'b0001, 1'b0, "lb_w0");
    apb_write(2'd0, 32'h0000_007F, 4'b0001, 1'b0, "lb_w1");
    apb_write(2'd0, 32'h0000_0000, 4'b0001, 1'b0, "lb_w2");
    repeat (650) @(posedge clk);
    apb_read(2'd0, 32'h0000_003C, "lb_r0");
    apb_read(2'd0, 32'h0000_007F, "lb_r1");
    apb_read(2'd0, 32'h0000_0000, "lb_r2");
    apb_read(2'd1, 32'h0000_000A, "lb_status");
    apb_read(2'd0, 32'h0000_0000, "rx_empty_read");
    loop = 1'b0;

    // TX FIFO full with tx_en=0, then release
    apb_write(2'd2, 32'h0000_000E, 4'b0001, 1'b0, "ctrl_tx_off");
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_expect(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b0);
      apb_write(2'd0, 32'h10 + 32'(i), 4'b0001, (i == 8), "fill_tx");
    end
    apb_read(2'd1, 32'h0008_0009, "status_tx_full");
    apb_write(2'd2, 32'h0000_000F, 4'b0001, 1'b0, "ctrl_tx_on");
    repeat (1400) @(posedge clk);
    apb_read(2'd1, 32'h0000_000A, "status_tx_drained");

    // RX overrun
    for (int i = 0; i < 9; i++) rx_frame(8'h41 + 8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1);
    apb_read(2'd1, 32'h0000_0826, "status_overrun");
    apb_write(2'd1, 32'h0000_0020, 4'b0001, 1'b0, "w1c_overrun");
    apb_read(2'd1, 32'h0000_0806, "status_overrun_clr");
    for (int i = 0; i < 8; i++) apb_read(2'd0, 32'h41 + 32'(i), "rx_drain");
    apb_read(2'd1, 32'h0000_000A, "status_rx_drained");

    // Parity and framing errors with err_irq_en
    apb_write(2'd2, 32'h0000_021F, 4'b0011, 1'b0, "ctrl_even_errirq");
    repeat (3) @(posedge clk); #1;
    check("irq_no_err", {31'd0, irq}, 32'd0);
    rx_frame(8'h55, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    check("irq_parity_err", {31'd0, irq}, 32'd1);
    apb_read(2'd1, 32'h0000_0142, "status_parity_err");
    rx_frame(8'h33, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    apb_read(2'd1, 32'h0000_01C2, "status_frame_err");
    apb_read(2'd0, 32'h0000_0055, "rx_parity_byte");
    apb_write(2'd1, 32'h0000_00E0, 4'b0001, 1'b0, "w1c_errors");
    apb_read(2'd1, 32'h0000_000A, "status_err_clr");
    repeat (3) @(posedge clk); #1;
    check("irq_err_clr", {31'd0, irq}, 32'd0);

    // Reset in the middle of a TX frame with a sticky error pending
    rx_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    tx_mon_en = 1'b0;
    apb_write(2'd0, 32'h0000_0000, 4'b0001, 1'b0, "tx_zero");
    repeat (40) @(posedge clk); #1;
    check("txd_mid_frame", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    #1;
    check("txd_async_reset", {31'd0, txd}, 32'd1);
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    tx_mon_en = 1'b1;
    apb_read(2'd1, 32'h0000_000A, "status_after_reset");
    apb_read(2'd2, 32'h0000_000F, "ctrl_after_reset");
    apb_read(2'd3, 32'h0000_001A, "baud_after_reset");
    seen = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seen = seen & txd;
    end
    check("txd_idle_after_reset", {31'd0, seen}, 32'd1);

    repeat (5) @(posedge clk);
    check("apb_queue_drained", exp_q.size(), 32'd0);
    check("tx_frames_drained", tx_exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
